// File: rtl/fpu_issue_arbiter_pkg.sv
// Shared opcodes and arbiter state encoding for the fpu issue arbiter.
package fpu_issue_arbiter_pkg;

    localparam logic [5:0] OP_FADD = 6'b000000;
    localparam logic [5:0] OP_FSUB = 6'b000001;
    localparam logic [5:0] OP_FMUL = 6'b000010;
    localparam logic [5:0] OP_FNEG = 6'b010000;
    localparam logic [5:0] OP_FCLT = 6'b100000;
    localparam logic [5:0] OP_FTOI = 6'b111000;
    localparam logic [5:0] OP_ITOF = 6'b111001;
    localparam logic [5:0] OP_MOV  = 6'b111101;
    localparam logic [5:0] OP_SET  = 6'b111110;
    localparam logic [5:0] OP_GET  = 6'b111111;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } arb_state_t;

endpackage

// File: rtl/fpu_issue_arbiter_if.sv
// Request, response and fpu-side signals of the issue arbiter.
// slave = arbiter view; master = the requesters/fpu environment view.
interface fpu_issue_arbiter_if #(
    parameter int NREQ = 2,
    parameter int IDW  = 1
);
    logic [NREQ-1:0]    req_valid;
    logic [NREQ-1:0]    req_ready;
    logic [NREQ*6-1:0]  req_op;
    logic [NREQ*5-1:0]  req_x1;
    logic [NREQ*5-1:0]  req_x2;
    logic [NREQ*5-1:0]  req_y;
    logic [NREQ*32-1:0] req_data;

    logic               resp_valid;
    logic               resp_ready;
    logic [IDW-1:0]     resp_id;
    logic [31:0]        resp_data32;
    logic               resp_data1;
    logic               resp_err;

    logic [4:0]         fpu_x1;
    logic [4:0]         fpu_x2;
    logic [4:0]         fpu_y;
    logic [5:0]         fpu_operation;
    logic [31:0]        fpu_in_data;
    logic               fpu_ready;
    logic               fpu_valid;
    logic               fpu_out_data1;
    logic [31:0]        fpu_out_data32;

    modport slave (
        input  req_valid, req_op, req_x1, req_x2, req_y, req_data,
        input  resp_ready,
        input  fpu_valid, fpu_out_data1, fpu_out_data32,
        output req_ready,
        output resp_valid, resp_id, resp_data32, resp_data1, resp_err,
        output fpu_x1, fpu_x2, fpu_y, fpu_operation, fpu_in_data, fpu_ready
    );

    modport master (
        output req_valid, req_op, req_x1, req_x2, req_y, req_data,
        output resp_ready,
        output fpu_valid, fpu_out_data1, fpu_out_data32,
        input  req_ready,
        input  resp_valid, resp_id, resp_data32, resp_data1, resp_err,
        input  fpu_x1, fpu_x2, fpu_y, fpu_operation, fpu_in_data, fpu_ready
    );

endinterface

// File: rtl/fpu_issue_arbiter_rr_arbiter.sv
// Round-robin picker: first asserted request scanning from i_ptr upward, wrapping.
module rr_arbiter #(
    parameter int NREQ = 2,
    parameter int IDW  = 1
) (
    input  logic [NREQ-1:0] i_req,
    input  logic [IDW-1:0]  i_ptr,
    output logic [NREQ-1:0] o_gnt,
    output logic [IDW-1:0]  o_gnt_idx,
    output logic            o_any
);

    always_comb begin
        o_gnt     = '0;
        o_gnt_idx = '0;
        o_any     = 1'b0;
        for (int k = 0; k < NREQ; k++) begin
            int idx;
            idx = (int'(i_ptr) + k) % NREQ;
            if (!o_any && i_req[idx]) begin
                o_any      = 1'b1;
                o_gnt[idx] = 1'b1;
                o_gnt_idx  = IDW'(idx);
            end
        end
    end

endmodule

// File: rtl/fpu_issue_arbiter.sv
// Shares one fpu between NREQ requesters: round-robin issue, one op in flight,
// result returned on a valid/ready handshake, timeout abort while waiting.
module fpu_issue_arbiter
    import fpu_issue_arbiter_pkg::*;
#(
    parameter int NREQ    = 2,
    parameter int IDW     = 1,
    parameter int TIMEOUT = 64
) (
    input  logic                 i_clk,
    input  logic                 i_rst,
    fpu_issue_arbiter_if.slave   io_bus,
    output logic                 o_busy,
    output logic                 o_err_sticky
);

    localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

    arb_state_t     r_state;
    logic [IDW-1:0] r_ptr;
    logic [IDW-1:0] r_gnt;
    logic [5:0]     r_op;
    logic [4:0]     r_x1;
    logic [4:0]     r_x2;
    logic [4:0]     r_y;
    logic [31:0]    r_in;
    logic [CW-1:0]  r_cnt;
    logic [31:0]    r_data32;
    logic           r_data1;
    logic           r_err;
    logic           r_err_sticky;
    logic           r_busy;
    logic           r_resp_valid;

    logic [NREQ-1:0] w_req;
    logic [NREQ-1:0] w_gnt;
    logic [IDW-1:0]  w_gnt_idx;
    logic            w_issue;
    logic            w_idle;
    logic [5:0]      w_sel_op;
    logic [4:0]      w_sel_x1;
    logic [4:0]      w_sel_x2;
    logic [4:0]      w_sel_y;
    logic [31:0]     w_sel_in;
    logic [IDW-1:0]  w_ptr_nxt;

    assign w_idle = (r_state == IDLE);

    // Requests are only visible to the picker in IDLE and never while reset is held,
    // so req_ready/fpu_ready are 0 in every other state and during reset.
    assign w_req = (w_idle && !i_rst) ? io_bus.req_valid : '0;

    rr_arbiter #(
        .NREQ (NREQ),
        .IDW  (IDW)
    ) u_rr (
        .i_req     (w_req),
        .i_ptr     (r_ptr),
        .o_gnt     (w_gnt),
        .o_gnt_idx (w_gnt_idx),
        .o_any     (w_issue)
    );

    assign w_sel_op  = io_bus.req_op  [int'(w_gnt_idx)*6  +: 6];
    assign w_sel_x1  = io_bus.req_x1  [int'(w_gnt_idx)*5  +: 5];
    assign w_sel_x2  = io_bus.req_x2  [int'(w_gnt_idx)*5  +: 5];
    assign w_sel_y   = io_bus.req_y   [int'(w_gnt_idx)*5  +: 5];
    assign w_sel_in  = io_bus.req_data[int'(w_gnt_idx)*32 +: 32];
    assign w_ptr_nxt = (w_gnt_idx == IDW'(NREQ-1)) ? '0 : w_gnt_idx + 1'b1;

    // Issue cycle steers the winner straight through; afterwards the latches hold the pins.
    assign io_bus.fpu_operation = w_idle ? w_sel_op : r_op;
    assign io_bus.fpu_x1        = w_idle ? w_sel_x1 : r_x1;
    assign io_bus.fpu_x2        = w_idle ? w_sel_x2 : r_x2;
    assign io_bus.fpu_y         = w_idle ? w_sel_y  : r_y;
    assign io_bus.fpu_in_data   = w_idle ? w_sel_in : r_in;
    assign io_bus.fpu_ready     = w_issue;
    assign io_bus.req_ready     = w_gnt;

    assign io_bus.resp_valid  = r_resp_valid;
    assign io_bus.resp_id     = r_gnt;
    assign io_bus.resp_data32 = r_data32;
    assign io_bus.resp_data1  = r_data1;
    assign io_bus.resp_err    = r_err;
    assign o_busy             = r_busy;
    assign o_err_sticky       = r_err_sticky;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state      <= IDLE;
            r_ptr        <= '0;
            r_gnt        <= '0;
            r_op         <= '0;
            r_x1         <= '0;
            r_x2         <= '0;
            r_y          <= '0;
            r_in         <= '0;
            r_cnt        <= '0;
            r_data32     <= '0;
            r_data1      <= 1'b0;
            r_err        <= 1'b0;
            r_err_sticky <= 1'b0;
            r_busy       <= 1'b0;
            r_resp_valid <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_issue) begin
                        r_gnt  <= w_gnt_idx;
                        r_op   <= w_sel_op;
                        r_x1   <= w_sel_x1;
                        r_x2   <= w_sel_x2;
                        r_y    <= w_sel_y;
                        r_in   <= w_sel_in;
                        r_ptr  <= w_ptr_nxt;
                        r_busy <= 1'b1;
                        // Zero-latency ops complete in the issue cycle itself.
                        if (io_bus.fpu_valid) begin
                            r_data32     <= io_bus.fpu_out_data32;
                            r_data1      <= io_bus.fpu_out_data1;
                            r_err        <= 1'b0;
                            r_resp_valid <= 1'b1;
                            r_state      <= RESP;
                        end else begin
                            r_cnt   <= '0;
                            r_state <= WAIT;
                        end
                    end
                end
                WAIT: begin
                    if (io_bus.fpu_valid) begin
                        r_data32     <= io_bus.fpu_out_data32;
                        r_data1      <= io_bus.fpu_out_data1;
                        r_err        <= 1'b0;
                        r_resp_valid <= 1'b1;
                        r_state      <= RESP;
                    end else if (r_cnt == CW'(TIMEOUT-1)) begin
                        r_err        <= 1'b1;
                        r_err_sticky <= 1'b1;
                        r_resp_valid <= 1'b1;
                        r_state      <= RESP;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                RESP: begin
                    // Returning to IDLE costs a cycle; this gap covers the fpu write-back.
                    if (io_bus.resp_ready) begin
                        r_resp_valid <= 1'b0;
                        r_busy       <= 1'b0;
                        r_state      <= IDLE;
                    end
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fpu_issue_arbiter.sv
// Randomized bench for fpu_issue_arbiter with a latency-programmable fpu model
// and a transaction-level reference for grant order, latency and results.
module tb_fpu_issue_arbiter;
    import fpu_issue_arbiter_pkg::*;

    localparam int NREQ    = 2;
    localparam int IDW     = 1;
    localparam int TIMEOUT = 16;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic busy;
    logic err_sticky;

    fpu_issue_arbiter_if #(.NREQ(NREQ), .IDW(IDW)) bus ();

    fpu_issue_arbiter #(
        .NREQ    (NREQ),
        .IDW     (IDW),
        .TIMEOUT (TIMEOUT)
    ) dut (
        .i_clk        (clk),
        .i_rst        (rst),
        .io_bus       (bus.slave),
        .o_busy       (busy),
        .o_err_sticky (err_sticky)
    );

    always #5 clk = ~clk;

    // fpu model: lat 0 answers in the issue cycle, lat N answers N cycles later, lat<0 never.
    int fpu_lat = 0;
    int fcnt = -1;

    function automatic logic [32:0] fpu_fn(logic [5:0] op, logic [4:0] x1, logic [4:0] x2,
                                           logic [4:0] y, logic [31:0] d);
        logic [31:0] r;
        r = (d * 32'd3) ^ {op, x1, x2, y, 11'h5a5};
        return {^r, r};
    endfunction

    assign bus.fpu_valid = (bus.fpu_ready && fpu_lat == 0) || (fcnt == 0);
    assign {bus.fpu_out_data1, bus.fpu_out_data32} =
        fpu_fn(bus.fpu_operation, bus.fpu_x1, bus.fpu_x2, bus.fpu_y, bus.fpu_in_data);

    always @(posedge clk or posedge rst) begin
        if (rst)                            fcnt <= -1;
        else if (bus.fpu_ready && fpu_lat > 0) fcnt <= fpu_lat - 1;
        else if (fcnt > 0)                  fcnt <= fcnt - 1;
        else                                fcnt <= -1;
    end

    int n_tests = 0;
    int n_fail  = 0;
    int rr_m    = 0;
    bit sticky_m = 1'b0;

    logic [5:0]  p_op [NREQ];
    logic [4:0]  p_x1 [NREQ];
    logic [4:0]  p_x2 [NREQ];
    logic [4:0]  p_y  [NREQ];
    logic [31:0] p_d  [NREQ];

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic set_payload(input int op_force);
        for (int i = 0; i < NREQ; i++) begin
            p_op[i] = (op_force >= 0) ? 6'(op_force) : 6'($urandom);
            p_x1[i] = 5'($urandom);
            p_x2[i] = 5'($urandom);
            p_y[i]  = 5'($urandom);
            p_d[i]  = $urandom;
            bus.req_op[i*6 +: 6]    = p_op[i];
            bus.req_x1[i*5 +: 5]    = p_x1[i];
            bus.req_x2[i*5 +: 5]    = p_x2[i];
            bus.req_y[i*5 +: 5]     = p_y[i];
            bus.req_data[i*32 +: 32] = p_d[i];
        end
    endtask

    // One transaction: offer vmask, expect RR winner, fpu answers after lat, hold resp_ready low.
    task automatic run_op(input logic [NREQ-1:0] vmask, input int lat, input int hold,
                          input int op_force);
        int w;
        int cycles;
        logic [32:0] exp_r;
        logic [5:0]  w_op;
        logic [31:0] w_d;
        @(negedge clk);
        set_payload(op_force);
        fpu_lat        = lat;
        bus.req_valid  = vmask;
        bus.resp_ready = 1'b0;
        #1;
        w = -1;
        for (int k = 0; k < NREQ; k++) begin
            int idx;
            idx = (rr_m + k) % NREQ;
            if (w < 0 && vmask[idx]) w = idx;
        end
        if (w < 0) begin
            chk("idle_req_ready", 64'(bus.req_ready), 64'(0));
            chk("idle_fpu_ready", 64'(bus.fpu_ready), 64'(0));
            chk("idle_busy", 64'(busy), 64'(0));
            bus.req_valid = '0;
            return;
        end
        chk("grant", 64'(bus.req_ready), 64'(1) << w);
        chk("issue_fpu_ready", 64'(bus.fpu_ready), 64'(1));
        chk("issue_op", 64'(bus.fpu_operation), 64'(p_op[w]));
        chk("issue_in_data", 64'(bus.fpu_in_data), 64'(p_d[w]));
        chk("issue_y", 64'(bus.fpu_y), 64'(p_y[w]));
        exp_r = fpu_fn(p_op[w], p_x1[w], p_x2[w], p_y[w], p_d[w]);
        w_op  = p_op[w];
        w_d   = p_d[w];
        rr_m  = (w + 1) % NREQ;
        cycles = 0;
        do begin
            @(negedge clk);
            cycles++;
            if (cycles == 1) begin
                bus.req_valid = '1;
                set_payload(-1);
            end
            #1;
            if (!bus.resp_valid) begin
                chk("wait_req_ready", 64'(bus.req_ready), 64'(0));
                chk("wait_fpu_ready", 64'(bus.fpu_ready), 64'(0));
                chk("wait_op_hold", 64'(bus.fpu_operation), 64'(w_op));
                chk("wait_data_hold", 64'(bus.fpu_in_data), 64'(w_d));
                chk("wait_busy", 64'(busy), 64'(1));
            end
        end while (!bus.resp_valid && cycles < TIMEOUT + 8);
        if (lat < 0) sticky_m = 1'b1;
        chk("resp_valid", 64'(bus.resp_valid), 64'(1));
        chk("resp_delay", 64'(cycles), 64'((lat < 0) ? TIMEOUT + 1 : lat + 1));
        chk("resp_id", 64'(bus.resp_id), 64'(w));
        chk("resp_err", 64'(bus.resp_err), 64'(lat < 0));
        chk("err_sticky", 64'(err_sticky), 64'(sticky_m));
        if (lat >= 0) begin
            chk("resp_data32", 64'(bus.resp_data32), 64'(exp_r[31:0]));
            chk("resp_data1", 64'(bus.resp_data1), 64'(exp_r[32]));
        end
        for (int h = 0; h < hold; h++) begin
            @(negedge clk);
            #1;
            chk("hold_valid", 64'(bus.resp_valid), 64'(1));
            chk("hold_id", 64'(bus.resp_id), 64'(w));
            chk("hold_req_ready", 64'(bus.req_ready), 64'(0));
            chk("hold_fpu_ready", 64'(bus.fpu_ready), 64'(0));
            if (lat >= 0) chk("hold_data32", 64'(bus.resp_data32), 64'(exp_r[31:0]));
        end
        bus.resp_ready = 1'b1;
        @(negedge clk);
        bus.resp_ready = 1'b0;
        bus.req_valid  = '0;
        #1;
        chk("done_valid", 64'(bus.resp_valid), 64'(0));
        chk("done_busy", 64'(busy), 64'(0));
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.req_valid  = '0;
        bus.resp_ready = 1'b0;
        set_payload(-1);
        repeat (2) @(negedge clk);
        #1;
        chk("rst_busy", 64'(busy), 64'(0));
        chk("rst_resp_valid", 64'(bus.resp_valid), 64'(0));
        chk("rst_err_sticky", 64'(err_sticky), 64'(0));
        chk("rst_req_ready", 64'(bus.req_ready), 64'(0));
        chk("rst_fpu_ready", 64'(bus.fpu_ready), 64'(0));
        rst = 1'b0;

        // Reset in the middle of a stalled op.
        @(negedge clk);
        set_payload(int'(OP_FMUL));
        fpu_lat       = -1;
        bus.req_valid = 2'b01;
        @(negedge clk);
        bus.req_valid = '0;
        repeat (3) @(negedge clk);
        #1;
        chk("midwait_busy", 64'(busy), 64'(1));
        bus.req_valid = 2'b11;
        rst = 1'b1;
        #1;
        chk("midrst_busy", 64'(busy), 64'(0));
        chk("midrst_resp_valid", 64'(bus.resp_valid), 64'(0));
        chk("midrst_req_ready", 64'(bus.req_ready), 64'(0));
        chk("midrst_fpu_ready", 64'(bus.fpu_ready), 64'(0));
        @(negedge clk);
        bus.req_valid = '0;
        rst  = 1'b0;
        rr_m = 0;
        sticky_m = 1'b0;

        // Both FADD after reset: pointer at 0 so req0 wins, then req1.
        run_op(2'b11, 2, 0, int'(OP_FADD));
        run_op(2'b11, 2, 0, int'(OP_FADD));
        run_op(2'b01, 0, 0, int'(OP_SET));
        run_op(2'b01, 3, 0, int'(OP_FMUL));
        run_op(2'b10, -1, 0, int'(OP_FMUL));
        run_op(2'b11, 1, 5, int'(OP_FADD));
        run_op(2'b00, 0, 0, -1);

        for (int t = 0; t < 150; t++) begin
            int lat;
            lat = ($urandom_range(0, 19) == 0) ? -1 : int'($urandom_range(0, 6));
            run_op(NREQ'($urandom_range(0, 3)), lat, int'($urandom_range(0, 3)), -1);
        end

        @(negedge clk);
        #1;
        chk("sticky_before_rst", 64'(err_sticky), 64'(sticky_m));
        rst = 1'b1;
        #1;
        chk("sticky_after_rst", 64'(err_sticky), 64'(0));
        @(negedge clk);
        rst = 1'b0;

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
